tile_feeder: RTL



---
 rtl/tile_feeder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tile_feeder.sv
// tile_feeder
//   Read-side sequencer for the 4x4 operand memory. A start request launches a
//   pass that walks the four read columns in a diagonally skewed wavefront
//   (column c starts c cycles after column 0). Read data returned by the
//   asynchronous read port is registered into a per-lane valid/data stream
//   feeding the systolic array edge.
//
//   Optional build macro: TILE_FEEDER_REVERSE_EN
//     defined   -> each lane streams elements 3,2,1,0
//     undefined -> each lane streams elements 0,1,2,3
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   start        request one pass (sampled in IDLE and DONE)
//   abort        synchronous cancel of a pass in progress (RUN only)
//   busy         high while in RUN
//   done         one-cycle pulse after a completed pass
//   rd_enable    per-column read enable to memory
//   rd_elem      4x2-bit element select, column c at [2c+1:2c]
//   rd_data      memory read data, lane c at [(c+1)*DATA_WIDTH-1:c*DATA_WIDTH]
//   feed_valid   per-lane registered valid
//   feed_data    per-lane registered data, same packing as rd_data
module tile_feeder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              rd_enable,
  output logic [7:0]              rd_elem,
  input  logic [4*DATA_WIDTH-1:0] rd_data,
  output logic [3:0]              feed_valid,
  output logic [4*DATA_WIDTH-1:0] feed_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              t_q, t_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [3:0]              feed_valid_q, feed_valid_d;
  logic [4*DATA_WIDTH-1:0] feed_data_q, feed_data_d;

  logic [3:0]              rd_enable_c;
  logic [7:0]              rd_elem_c;
  logic [2:0]              lane_off;

  // Wavefront decode: lane c is active while c <= t <= c+3, element t-c.
  always_comb begin
    rd_enable_c = '0;
    rd_elem_c   = '0;
    lane_off    = '0;
    if (state_q == S_RUN) begin
      for (int unsigned c = 0; c < 4; c++) begin
        lane_off = t_q - 3'(c);
        if ((t_q >= 3'(c)) && (lane_off <= 3'd3)) begin
          rd_enable_c[c] = 1'b1;
`ifdef TILE_FEEDER_REVERSE_EN
          rd_elem_c[2*c +: 2] = 2'd3 - lane_off[1:0];
`else
          rd_elem_c[2*c +: 2] = lane_off[1:0];
`endif
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    feed_valid_d = '0;
    feed_data_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          t_d     = '0;
        end else begin
          // Read port is asynchronous: data for this cycle's address is
          // captured on this same edge.
          feed_valid_d = rd_enable_c;
          for (int unsigned c = 0; c < 4; c++) begin
            if (rd_enable_c[c]) begin
              feed_data_d[c*DATA_WIDTH +: DATA_WIDTH] = rd_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          if (t_q == 3'd6) begin
            state_d = S_DONE;
            t_d     = '0;
          end else begin
            t_d = t_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        t_d     = '0;
        state_d = start ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
    // Status flags are registered copies of the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      feed_valid_q <= '0;
      feed_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      feed_valid_q <= feed_valid_d;
      feed_data_q  <= feed_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_enable  = rd_enable_c;
  assign rd_elem    = rd_elem_c;
  assign feed_valid = feed_valid_q;
  assign feed_data  = feed_data_q;

endmodule
